raizing_gfx_arbiter: RTL

Parametrised graphics-ROM request arbiter for the Raizing video subsystem. It shares one SDRAM graphics port among CHANNELS layer fetchers (object, scroll 0/1/2, and later layers) that currently each own a dedicated port. Each channel gets a one-entry address/data cache, and pending misses are served round-robin. A FLUSH input invalidates all caches on tile-bank writes, and an optional watchdog recovers from a stalled ROM port.

---
 rtl/raizing_gfx_arbiter.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/raizing_gfx_arbiter.sv
// Shared graphics-ROM port arbiter: one-entry cache per channel, round-robin miss service.
// Optional stalled-port watchdog enabled by defining RAIZING_GFXARB_WATCHDOG_EN.
module raizing_gfx_arbiter #(
   parameter int CHANNELS = 4,
   parameter int AW       = 22,
   parameter int DW       = 32,
   parameter int TIMEOUT  = 1023
) (
   input  logic                   CLK,
   input  logic                   RESET_N,
   input  logic [CHANNELS-1:0]    REQ_CS,
   input  logic [CHANNELS*AW-1:0] REQ_ADDR,
   output logic [CHANNELS-1:0]    REQ_OK,
   output logic [CHANNELS*DW-1:0] REQ_DOUT,
   input  logic                   FLUSH,
   output logic                   ROM_CS,
   output logic [AW-1:0]          ROM_ADDR,
   input  logic                   ROM_OK,
   input  logic [DW-1:0]          ROM_DOUT,
   output logic [2:0]             GRANT,
   output logic                   TIMEOUT_ERR
);

   localparam int IW = $clog2(CHANNELS);

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_GAP} state_e;

   if (CHANNELS < 2 || CHANNELS > 8) begin : g_bad_channels
      $error("raizing_gfx_arbiter: CHANNELS must be in 2..8");
   end
   if (TIMEOUT < 1 || TIMEOUT > 1023) begin : g_bad_timeout
      $error("raizing_gfx_arbiter: TIMEOUT must fit the 10-bit watchdog counter");
   end

   state_e                state_q, state_d;
   logic [CHANNELS-1:0]   valid_q, valid_d;
   logic [AW-1:0]         caddr_q [CHANNELS];
   logic [AW-1:0]         caddr_d [CHANNELS];
   logic [DW-1:0]         cdata_q [CHANNELS];
   logic [DW-1:0]         cdata_d [CHANNELS];
   logic [AW-1:0]         rom_addr_q, rom_addr_d;
   logic [IW-1:0]         grant_q, grant_d;
   logic [IW-1:0]         last_q, last_d;

   logic [CHANNELS-1:0]   hit;
   logic [CHANNELS-1:0]   pending;
   logic                  sel_found;
   logic [IW-1:0]         sel_idx;

`ifdef RAIZING_GFXARB_WATCHDOG_EN
   localparam logic [9:0] WD_LIMIT = 10'(TIMEOUT);
   logic [9:0] wd_cnt_q, wd_cnt_d;
   logic       timeout_err_q, timeout_err_d;
`endif

   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         hit[i]     = valid_q[i] & REQ_CS[i] & (REQ_ADDR[i*AW +: AW] == caddr_q[i]);
         pending[i] = REQ_CS[i] & ~hit[i];
      end
   end

   assign REQ_OK = hit;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_dout
      assign REQ_DOUT[g*DW +: DW] = cdata_q[g];
   end

   // First pending channel strictly after the last one served, wrapping.
   always_comb begin : arb
      int c;
      c         = 0;
      sel_found = 1'b0;
      sel_idx   = last_q;
      for (int k = 1; k <= CHANNELS; k++) begin
         c = (int'(last_q) + k) % CHANNELS;
         if (!sel_found && pending[c]) begin
            sel_found = 1'b1;
            sel_idx   = IW'(c);
         end
      end
   end

   // NOTE: every output of this block gets a default before the case so no path
   // leaves a variable unassigned, which would otherwise infer a latch.
   always_comb begin
      state_d    = state_q;
      valid_d    = valid_q;
      caddr_d    = caddr_q;
      cdata_d    = cdata_q;
      rom_addr_d = rom_addr_q;
      grant_d    = grant_q;
      last_d     = last_q;
`ifdef RAIZING_GFXARB_WATCHDOG_EN
      wd_cnt_d      = wd_cnt_q;
      timeout_err_d = timeout_err_q;
`endif
      case (state_q)
         // GAP is also an arbitration slot, so back-to-back fetches see ROM_CS low
         // for exactly one cycle.
         ST_IDLE, ST_GAP: begin
            if (sel_found) begin
               rom_addr_d = REQ_ADDR[int'(sel_idx)*AW +: AW];
               grant_d    = sel_idx;
               state_d    = ST_ISSUE;
            end else begin
               grant_d = '0;
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_WAIT;
`ifdef RAIZING_GFXARB_WATCHDOG_EN
            wd_cnt_d = '0;
`endif
         end
         ST_WAIT: begin
            if (ROM_OK) begin
               cdata_d[grant_q] = ROM_DOUT;
               caddr_d[grant_q] = rom_addr_q;
               valid_d[grant_q] = 1'b1;
               last_d           = grant_q;
               state_d          = ST_GAP;
            end
`ifdef RAIZING_GFXARB_WATCHDOG_EN
            else begin
               wd_cnt_d = wd_cnt_q + 10'd1;
               if (wd_cnt_d == WD_LIMIT) begin
                  timeout_err_d = 1'b1;
                  state_d       = ST_GAP;
               end
            end
`endif
         end
         default: state_d = ST_IDLE;
      endcase
      // A flush coinciding with a fill still invalidates the freshly filled entry.
      if (FLUSH) valid_d = '0;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // pre-edge values regardless of process evaluation order.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         rom_addr_q <= '0;
         grant_q    <= '0;
         last_q     <= IW'(CHANNELS - 1);
         // NOTE: the cache arrays are reset because REQ_DOUT is visible at all
         // times and must read zero out of reset.
         for (int i = 0; i < CHANNELS; i++) begin
            caddr_q[i] <= '0;
            cdata_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         valid_q    <= valid_d;
         caddr_q    <= caddr_d;
         cdata_q    <= cdata_d;
         rom_addr_q <= rom_addr_d;
         grant_q    <= grant_d;
         last_q     <= last_d;
      end
   end

`ifdef RAIZING_GFXARB_WATCHDOG_EN
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         wd_cnt_q      <= '0;
         timeout_err_q <= 1'b0;
      end else begin
         wd_cnt_q      <= wd_cnt_d;
         timeout_err_q <= timeout_err_d;
      end
   end
   assign TIMEOUT_ERR = timeout_err_q;
`else
   assign TIMEOUT_ERR = 1'b0;
`endif

   assign ROM_CS   = (state_q == ST_ISSUE) || (state_q == ST_WAIT);
   assign ROM_ADDR = rom_addr_q;
   assign GRANT    = 3'(grant_q);

endmodule
